decode_lock_mask: RTL and testbench
===================================

DECODE_LOCK_MASK -- requirements
Module: decode_lock_mask

Interface
REQ-001 Parameter: DEBUG, default "FALSE", "TRUE" enables debug-probe marking (see Configuration).
REQ-002 px_clk  input  1  sole clock; all logic on rising edge.
REQ-003 px_reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level request; sampled in IDLE, held high by requester until done_out seen.
REQ-005 lock_mask_din  input  32  per-tap lock mask, bit i = 1 means delay tap i locked; stable while start high.
REQ-006 delay_min_dout  output  8  first tap of widest locked run.
REQ-007 delay_max_dout  output  8  last tap of widest locked run.
REQ-008 delay_range_dout  output  8  length of widest run (max-min+1), 0 if no locked tap.
REQ-009 done_out  output  1  result valid/complete flag.

Function
REQ-010 States: IDLE, SCAN, FINAL, DONE; all outputs registered.
REQ-011 IDLE: if start=1, latch lock_mask_din into internal mask, clear bit index, run counters and best-run registers -> SCAN; else stay.
REQ-012 SCAN: one bit per cycle, index 0..31 ascending; exactly 32 cycles, then -> FINAL.
REQ-013 Bit=1: if current run length 0, run start = index; run length +1.
REQ-014 Bit=0: if run length > best length (strict), best = current run; run length cleared.
REQ-015 FINAL: apply REQ-014 comparison to trailing run (handles run ending at bit 31); load outputs: min=best start, max=best start+best length-1, range=best length; -> DONE.
REQ-016 No run: min=0, max=0, range=0.
REQ-017 Ties: lowest-index run wins; no wrap-around between bit 31 and bit 0.
REQ-018 Range 0..32; all arithmetic 8-bit, zero-extended indices.
REQ-019 DONE: done_out=1; stay while start=1; start=0 -> IDLE with done_out=0 next cycle.
REQ-020 done_out first high 34 cycles after the edge sampling start=1 in IDLE (32 SCAN + FINAL + DONE entry).
REQ-021 start dropping during SCAN/FINAL ignored; scan completes; done_out high at least one cycle.
REQ-022 Result outputs hold last values until next FINAL; not cleared by new start.
REQ-023 lock_mask_din changes after latch have no effect on current scan.

Reset
REQ-024 px_reset=1 at any edge, including mid-scan: state IDLE, done_out=0, delay_min/max/range=0, internal counters/mask cleared; reset dominates start.

Configuration
REQ-025 Macro DECODE_LOCK_MASK_DEBUG_EN defined and DEBUG="TRUE": state, index, mask, run and best registers carry mark_debug="true" probe copies.
REQ-026 Macro undefined (or DEBUG!="TRUE"): no probe signals; ports, timing and results identical in both builds.

Verification
REQ-027 mask 0x0FF0_00F0, start held -> done_out at cycle 34; min 20, max 27, range 8.
REQ-028 mask 0xFFFF_FFFF -> min 0, max 31, range 32; mask 0x0000_0000 -> 0, 0, 0.
REQ-029 mask 0x00F0_0F00 (equal runs 8..11, 20..23) -> min 8, max 11, range 4 (tie to lowest).
REQ-030 mask 0x8000_0001 -> min 0, max 0, range 1 (no wrap); then mask 0xC000_0000 -> min 30, max 31, range 2.
REQ-031 Handshake: done_out stays high while start high; start low -> done_out 0 next cycle; restart after 4 idle cycles gives fresh result, old outputs held meanwhile.
REQ-032 px_reset at SCAN cycle 10 -> all outputs 0, IDLE; new start yields correct result 34 cycles later.

Source files
------------

// File: rtl/decode_lock_mask.sv
// decode_lock_mask
//   Scans a 32-bit delay-tap lock mask one bit per cycle and reports the
//   widest contiguous run of locked taps.
//   - delay_min_dout   : first tap of the run
//   - delay_max_dout   : last tap of the run
//   - delay_range_dout : number of taps in the run
//   If two runs are equally wide, the one with the lower index wins.
//   A run at bit 31 does not wrap around to bit 0.
//   If no tap is locked, all three results are 0.
//
//   Handshake:
//   - The requester raises start and holds it until done_out is seen.
//   - done_out stays high while start is held.
//   - done_out is always high for at least one cycle, even if start
//     dropped early.
//   - Results keep their last value until the next scan completes.
//
//   Build option: define DECODE_LOCK_MASK_DEBUG_EN and set DEBUG = "TRUE".
//   This attaches mark_debug probe copies of the FSM state, the scan index,
//   the latched mask and the run/best registers. Ports, timing and results
//   are identical with or without the option.

module decode_lock_mask #(
  parameter string DEBUG = "FALSE"
) (
  input  logic        px_clk,
  input  logic        px_reset,
  input  logic        start,
  input  logic [31:0] lock_mask_din,
  output logic [7:0]  delay_min_dout,
  output logic [7:0]  delay_max_dout,
  output logic [7:0]  delay_range_dout,
  output logic        done_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd31;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  state_t      state_reg;
  logic [31:0] mask_reg;        // snapshot of lock_mask_din taken in IDLE
  logic [4:0]  idx_reg;         // tap currently being examined
  logic [7:0]  run_start_reg;   // first tap of the run in progress
  logic [7:0]  run_len_reg;     // length of the run in progress
  logic [7:0]  best_start_reg;  // first tap of the widest closed run so far
  logic [7:0]  best_len_reg;    // length of the widest closed run so far
  logic [7:0]  min_reg;
  logic [7:0]  max_reg;
  logic [7:0]  range_reg;
  logic        done_reg;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic       cur_bit;
  logic [7:0] idx_ext;
  logic       run_beats_best;
  logic [7:0] run_start_next;
  logic [7:0] run_len_next;
  logic [7:0] best_start_next;
  logic [7:0] best_len_next;
  logic [7:0] fin_start;
  logic [7:0] fin_len;
  logic [7:0] min_next;
  logic [7:0] max_next;
  logic [7:0] range_next;

  assign cur_bit = mask_reg[idx_reg];
  assign idx_ext = {3'b000, idx_reg};

  // The comparison is strict, so an equally wide run found later never
  // displaces an earlier one. This is what makes the lowest index win ties.
  assign run_beats_best = (run_len_reg > best_len_reg);

  // Per-bit run tracking.
  //   Set bit:   extends the current run, or opens a new one here.
  //   Clear bit: closes the current run and promotes it if it is wider.
  always_comb begin
    run_start_next  = run_start_reg;
    run_len_next    = run_len_reg;
    best_start_next = best_start_reg;
    best_len_next   = best_len_reg;
    if (cur_bit) begin
      if (run_len_reg == 8'd0) begin
        run_start_next = idx_ext;
      end
      run_len_next = run_len_reg + 8'd1;
    end else begin
      if (run_beats_best) begin
        best_start_next = run_start_reg;
        best_len_next   = run_len_reg;
      end
      run_len_next = 8'd0;
    end
  end

  // Close out a run still open after bit 31, then form the result fields.
  // The zero-length guard keeps max from underflowing to 255 when no tap
  // is locked.
  always_comb begin
    fin_start  = run_beats_best ? run_start_reg : best_start_reg;
    fin_len    = run_beats_best ? run_len_reg   : best_len_reg;
    min_next   = 8'd0;
    max_next   = 8'd0;
    range_next = 8'd0;
    if (fin_len != 8'd0) begin
      min_next   = fin_start;
      max_next   = fin_start + fin_len - 8'd1;
      range_next = fin_len;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM. All outputs come straight from registers.
  //   IDLE  : latch the mask and clear the trackers.
  //   SCAN  : examine exactly 32 bits.
  //   FINAL : publish the result.
  //   DONE  : raise done_out one cycle after entry, so done_out first
  //           rises 34 edges after start is sampled. Leave only once
  //           done_out has been visible and start is low.
  // ---------------------------------------------------------------------
  always_ff @(posedge px_clk) begin
    if (px_reset) begin
      state_reg      <= IDLE;
      mask_reg       <= 32'd0;
      idx_reg        <= 5'd0;
      run_start_reg  <= 8'd0;
      run_len_reg    <= 8'd0;
      best_start_reg <= 8'd0;
      best_len_reg   <= 8'd0;
      min_reg        <= 8'd0;
      max_reg        <= 8'd0;
      range_reg      <= 8'd0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            mask_reg       <= lock_mask_din;
            idx_reg        <= 5'd0;
            run_start_reg  <= 8'd0;
            run_len_reg    <= 8'd0;
            best_start_reg <= 8'd0;
            best_len_reg   <= 8'd0;
            state_reg      <= SCAN;
          end
        end

        SCAN: begin
          run_start_reg  <= run_start_next;
          run_len_reg    <= run_len_next;
          best_start_reg <= best_start_next;
          best_len_reg   <= best_len_next;
          idx_reg        <= idx_reg + 5'd1;
          if (idx_reg == LAST_IDX) begin
            state_reg <= FINAL;
          end
        end

        FINAL: begin
          best_start_reg <= fin_start;
          best_len_reg   <= fin_len;
          min_reg        <= min_next;
          max_reg        <= max_next;
          range_reg      <= range_next;
          state_reg      <= DONE;
        end

        DONE: begin
          if (done_reg && !start) begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign delay_min_dout   = min_reg;
  assign delay_max_dout   = max_reg;
  assign delay_range_dout = range_reg;
  assign done_out         = done_reg;

  // ---------------------------------------------------------------------
  // Optional on-chip debug probes
  // ---------------------------------------------------------------------
`ifdef DECODE_LOCK_MASK_DEBUG_EN
  generate
    if (DEBUG == "TRUE") begin : g_debug
      (* mark_debug = "true" *) logic [1:0]  dbg_state;
      (* mark_debug = "true" *) logic [4:0]  dbg_idx;
      (* mark_debug = "true" *) logic [31:0] dbg_mask;
      (* mark_debug = "true" *) logic [7:0]  dbg_run_start;
      (* mark_debug = "true" *) logic [7:0]  dbg_run_len;
      (* mark_debug = "true" *) logic [7:0]  dbg_best_start;
      (* mark_debug = "true" *) logic [7:0]  dbg_best_len;

      // Plain wire copies, so the probes add no extra timing.
      assign dbg_state      = state_reg;
      assign dbg_idx        = idx_reg;
      assign dbg_mask       = mask_reg;
      assign dbg_run_start  = run_start_reg;
      assign dbg_run_len    = run_len_reg;
      assign dbg_best_start = best_start_reg;
      assign dbg_best_len   = best_len_reg;
    end
  endgenerate
`else
  // Probes are compiled out. DEBUG is still consulted, so the parameter has
  // the same meaning in both builds.
  generate
    if (DEBUG == "TRUE") begin : g_debug_off
    end
  endgenerate
`endif

endmodule

// File: tb/tb_decode_lock_mask.sv
// tb_decode_lock_mask
//   Self-checking bench for decode_lock_mask.
//   - Known vectors come from a table.
//   - Random masks are checked against a run-enumeration reference model.
//   - Hand sequences cover the handshake, an early start drop, a mask
//     change after the latch, reset in mid-scan and reset priority.

module tb_decode_lock_mask;

  logic        px_clk;
  logic        px_reset;
  logic        start;
  logic [31:0] lock_mask_din;
  logic [7:0]  delay_min_dout;
  logic [7:0]  delay_max_dout;
  logic [7:0]  delay_range_dout;
  logic        done_out;

  int n_total;
  int n_pass;

  decode_lock_mask dut (
    .px_clk           (px_clk),
    .px_reset         (px_reset),
    .start            (start),
    .lock_mask_din    (lock_mask_din),
    .delay_min_dout   (delay_min_dout),
    .delay_max_dout   (delay_max_dout),
    .delay_range_dout (delay_range_dout),
    .done_out         (done_out)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  typedef struct {
    logic [31:0] mask;
    logic [7:0]  exp_min;
    logic [7:0]  exp_max;
    logic [7:0]  exp_range;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_result(input string name, input logic [7:0] mn, input logic [7:0] mx,
                              input logic [7:0] rg);
    check({name, "_min"},   {24'd0, delay_min_dout},   {24'd0, mn});
    check({name, "_max"},   {24'd0, delay_max_dout},   {24'd0, mx});
    check({name, "_range"}, {24'd0, delay_range_dout}, {24'd0, rg});
  endtask

  // Reference model: enumerate every maximal run of ones.
  // Keep the first run with the greatest length.
  function automatic void model(input logic [31:0] m, output logic [7:0] mn,
                                output logic [7:0] mx, output logic [7:0] rg);
    int best_s;
    int best_l;
    best_s = 0;
    best_l = 0;
    for (int s = 0; s < 32; s++) begin
      if (m[s] && (s == 0 || !m[s-1])) begin
        int l;
        l = 0;
        while (s + l < 32 && m[s+l]) l++;
        if (l > best_l) begin
          best_l = l;
          best_s = s;
        end
      end
    end
    if (best_l == 0) begin
      mn = 8'd0; mx = 8'd0; rg = 8'd0;
    end else begin
      mn = 8'(best_s); mx = 8'(best_s + best_l - 1); rg = 8'(best_l);
    end
  endfunction

  // Start a scan of m.
  // - m_after is driven onto lock_mask_din right after the latch edge.
  // - hold keeps start high until done_out; extra adds cycles of holding
  //   after done_out, checking it stays high.
  // - Finishes by dropping start and checking done_out clears next edge.
  task automatic run_mask(input string name, input logic [31:0] m, input logic [31:0] m_after,
                          input bit hold, input int extra);
    int lat;
    lat = 0;
    lock_mask_din = m;
    start = 1'b1;
    @(posedge px_clk); #1;
    lock_mask_din = m_after;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge px_clk); #1;
      if (done_out) lat = k;
    end
    check({name, "_latency"}, lat, 34);
    for (int k = 0; k < extra; k++) begin
      @(posedge px_clk); #1;
      check({name, "_done_hold"}, {31'd0, done_out}, 32'd1);
    end
    start = 1'b0;
    @(posedge px_clk); #1;
    check({name, "_done_clear"}, {31'd0, done_out}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  rg;
    logic [31:0] rm;
    bit          seen;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{32'h0FF0_00F0, 8'd20, 8'd27, 8'd8};
    vecs[1] = '{32'hFFFF_FFFF, 8'd0,  8'd31, 8'd32};
    vecs[2] = '{32'h0000_0000, 8'd0,  8'd0,  8'd0};
    vecs[3] = '{32'h00F0_0F00, 8'd8,  8'd11, 8'd4};
    vecs[4] = '{32'h8000_0001, 8'd0,  8'd0,  8'd1};
    vecs[5] = '{32'hC000_0000, 8'd30, 8'd31, 8'd2};

    // Reset state
    px_reset = 1'b1;
    start = 1'b0;
    lock_mask_din = 32'd0;
    repeat (3) @(posedge px_clk);
    #1;
    px_reset = 1'b0;
    check("reset_done", {31'd0, done_out}, 32'd0);
    check_result("reset", 8'd0, 8'd0, 8'd0);

    // Table-driven known vectors
    for (int i = 0; i < 6; i++) begin
      run_mask($sformatf("vec%0d", i), vecs[i].mask, vecs[i].mask, 1'b1, 0);
      check_result($sformatf("vec%0d", i), vecs[i].exp_min, vecs[i].exp_max, vecs[i].exp_range);
      $display("vec%0d mask=%08h min=%0d max=%0d range=%0d", i, vecs[i].mask,
               delay_min_dout, delay_max_dout, delay_range_dout);
    end

    // Handshake:
    // - done_out holds while start is high.
    // - Old result is held through 4 idle cycles.
    // - A restart produces a fresh result.
    run_mask("hs", 32'h0FF0_00F0, 32'h0FF0_00F0, 1'b1, 5);
    seen = 1'b0;
    repeat (4) begin
      @(posedge px_clk); #1;
      if (done_out) seen = 1'b1;
    end
    check("hs_idle_done", {31'd0, seen}, 32'd0);
    check_result("hs_held", 8'd20, 8'd27, 8'd8);
    run_mask("hs_restart", 32'hC000_0000, 32'hC000_0000, 1'b1, 0);
    check_result("hs_restart", 8'd30, 8'd31, 8'd2);
    $display("handshake min=%0d max=%0d range=%0d", delay_min_dout, delay_max_dout, delay_range_dout);

    // start dropped right after latch, and the mask changes under the scan
    run_mask("drop", 32'h0000_3F00, 32'hFFFF_FFFF, 1'b0, 0);
    check_result("drop", 8'd8, 8'd13, 8'd6);
    $display("early drop min=%0d max=%0d range=%0d", delay_min_dout, delay_max_dout, delay_range_dout);

    // Reset at SCAN cycle 10, then a clean restart
    lock_mask_din = 32'h00FF_0000;
    start = 1'b1;
    @(posedge px_clk); #1;
    repeat (10) @(posedge px_clk);
    #1;
    px_reset = 1'b1;
    start = 1'b0;
    @(posedge px_clk); #1;
    px_reset = 1'b0;
    check("midrst_done", {31'd0, done_out}, 32'd0);
    check_result("midrst", 8'd0, 8'd0, 8'd0);
    run_mask("midrst_restart", 32'h0FF0_00F0, 32'h0FF0_00F0, 1'b1, 0);
    check_result("midrst_restart", 8'd20, 8'd27, 8'd8);
    $display("mid-scan reset recovery min=%0d max=%0d range=%0d", delay_min_dout, delay_max_dout,
             delay_range_dout);

    // Reset dominates start
    px_reset = 1'b1;
    start = 1'b1;
    lock_mask_din = 32'hFFFF_FFFF;
    @(posedge px_clk); #1;
    px_reset = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge px_clk); #1;
      if (done_out) seen = 1'b1;
    end
    check("rstdom_done", {31'd0, seen}, 32'd0);
    check_result("rstdom", 8'd0, 8'd0, 8'd0);

    // Randomised masks against the reference model
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: rm = $urandom;
        1: rm = $urandom & $urandom;
        default: begin
          int a;
          int b;
          a = $urandom_range(0, 31);
          b = $urandom_range(a, 31);
          rm = ((32'hFFFF_FFFF >> (31 - b)) & (32'hFFFF_FFFF << a)) | ($urandom & $urandom & $urandom);
        end
      endcase
      model(rm, mn, mx, rg);
      run_mask($sformatf("rnd%0d", i), rm, $urandom, (i % 2) == 0, 0);
      check_result($sformatf("rnd%0d", i), mn, mx, rg);
      $display("rnd%0d mask=%08h min=%0d max=%0d range=%0d", i, rm,
               delay_min_dout, delay_max_dout, delay_range_dout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
